// File: rtl/game_timer_pkg.sv
// Shared types and constants for the game countdown timer.
// The optional HUD readout is enabled with the GAME_TIMER_BCD_EN macro.
// Its digit conversion helper is defined here.
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    PAUSED   = 2'd2,
    DONE     = 2'd3
  } timer_state_e;

  localparam int unsigned DEFAULT_TICK_THRESHOLD = 25_000_000;
  localparam int unsigned DEFAULT_START_VALUE    = 60;
  localparam int unsigned DEFAULT_MAX_VALUE      = 999;
  localparam int unsigned DEFAULT_WARN_LEVEL     = 10;
  localparam int unsigned DEFAULT_WIDTH          = 10;

  // Converts a value below 1000 into three packed BCD digits:
  // hundreds, then tens, then ones.
  function automatic logic [11:0] to_bcd(input int unsigned value);
    int unsigned hundreds;
    int unsigned tens;
    int unsigned ones;
    hundreds = (value / 100) % 10;
    tens     = (value / 10) % 10;
    ones     = value % 10;
    return {hundreds[3:0], tens[3:0], ones[3:0]};
  endfunction

endpackage

// File: rtl/game_timer_prescaler.sv
// Unit-tick generator for the game timer.
// It counts 0..TICK_THRESHOLD-1 while enabled and raises tick on the wrap cycle.
// While enable is low, it holds its partial count.
module game_timer_prescaler #(
  parameter int unsigned TICK_THRESHOLD = 25_000_000
) (
  input  logic vga_clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_THRESHOLD);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TICK_THRESHOLD - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = enable && (count_q == LAST_COUNT);

  // Next count: clear wins, otherwise advance and wrap when enabled.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tick ? '0 : count_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/game_timer.sv
// Game countdown timer with pause, time-bonus add, warning and expiry.
// Macro GAME_TIMER_BCD_EN adds the bcd_digits HUD output.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int unsigned TICK_THRESHOLD = DEFAULT_TICK_THRESHOLD,
  parameter int unsigned START_VALUE    = DEFAULT_START_VALUE,
  parameter int unsigned MAX_VALUE      = DEFAULT_MAX_VALUE,
  parameter int unsigned WARN_LEVEL     = DEFAULT_WARN_LEVEL,
  parameter int unsigned WIDTH          = DEFAULT_WIDTH
) (
  input  logic             vga_clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             add_valid,
  input  logic [WIDTH-1:0] add_amount,
  output logic [WIDTH-1:0] seconds,
  output logic             running,
  output logic             warning,
  output logic             done,
  output logic             expired
`ifdef GAME_TIMER_BCD_EN
  ,
  output logic [11:0]      bcd_digits
`endif
);

  localparam logic [WIDTH-1:0] START_W = WIDTH'(START_VALUE);
  localparam logic [WIDTH:0]   MAX_X   = (WIDTH + 1)'(MAX_VALUE);
  localparam logic [WIDTH-1:0] WARN_W  = WIDTH'(WARN_LEVEL);

  timer_state_e     state_q;
  timer_state_e     state_d;
  logic [WIDTH-1:0] seconds_q;
  logic [WIDTH-1:0] seconds_d;
  logic             running_q;
  logic             warning_q;
  logic             warning_d;
  logic             done_q;
  logic             expired_q;
  logic             expired_d;
  logic [WIDTH:0]   base;
  logic [WIDTH:0]   sum;
  logic             tick;
  logic             pre_enable;
  logic             pre_clear;

  // The prescaler advances whenever the timer is live and not held by pause.
  // This includes the PAUSED-to-COUNTING resume cycle.
  assign pre_enable = !start && !pause && (state_q == COUNTING || state_q == PAUSED);
  assign pre_clear  = start || (state_q == IDLE) || (state_q == DONE);

  game_timer_prescaler #(
    .TICK_THRESHOLD(TICK_THRESHOLD)
  ) u_prescaler (
    .vga_clock(vga_clock),
    .reset    (reset),
    .enable   (pre_enable),
    .clear    (pre_clear),
    .tick     (tick)
  );

  // Next-state, next-seconds and expiry decisions.
  // start dominates; tick and add are merged at WIDTH+1 bits before saturation.
  always_comb begin
    state_d   = state_q;
    seconds_d = seconds_q;
    expired_d = 1'b0;
    base      = {1'b0, seconds_q};
    sum       = base;
    if (start) begin
      seconds_d = START_W;
      if (START_VALUE == 0) begin
        state_d   = DONE;
        expired_d = 1'b1;
      end else begin
        state_d = pause ? PAUSED : COUNTING;
      end
    end else begin
      case (state_q)
        COUNTING, PAUSED: begin
          if (tick && seconds_q != '0) begin
            base = base - (WIDTH + 1)'(1);
          end
          sum = add_valid ? base + {1'b0, add_amount} : base;
          seconds_d = (sum > MAX_X) ? MAX_X[WIDTH-1:0] : sum[WIDTH-1:0];
          if (tick && seconds_d == '0) begin
            state_d   = DONE;
            expired_d = 1'b1;
          end else if (state_q == COUNTING && pause) begin
            state_d = PAUSED;
          end else if (state_q == PAUSED && !pause) begin
            state_d = COUNTING;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    warning_d = (state_d == COUNTING || state_d == PAUSED)
                && (seconds_d != '0) && (seconds_d <= WARN_W);
  end

  // Timer FSM with registered outputs.
  // Each output reflects the new state one cycle after its cause.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state_q   <= IDLE;
      seconds_q <= START_W;
      running_q <= 1'b0;
      warning_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seconds_q <= seconds_d;
      running_q <= (state_d == COUNTING);
      warning_q <= warning_d;
      done_q    <= (state_d == DONE);
      expired_q <= expired_d;
    end
  end

  assign seconds = seconds_q;
  assign running = running_q;
  assign warning = warning_q;
  assign done    = done_q;
  assign expired = expired_q;

`ifdef GAME_TIMER_BCD_EN
  logic [11:0] bcd_q;

  // HUD digits track the seconds register in the same cycle.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      bcd_q <= to_bcd(START_VALUE);
    end else begin
      bcd_q <= to_bcd(32'(seconds_d));
    end
  end

  assign bcd_digits = bcd_q;
`else
  // Without the HUD option there is no decimal readout.
`endif

endmodule
